// File: rtl/core_step_ctrl_pkg.sv
// Shared encodings and board defaults for the core execution-rate controller.
// mode_sel encodes HALT=00, RUN=01, SLOW=10, STEP=11; the matching FSM states reuse those codes.
package core_step_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_HALT    = 3'd0,
    ST_RUN     = 3'd1,
    ST_SLOW    = 3'd2,
    ST_STEP    = 3'd3,
    ST_BP_HALT = 3'd4
  } state_t;

  // Alhambra-II 12 MHz: 1 s slow tick, 5 ms debounce
  localparam logic [23:0] DIV_12MHZ = 24'd11999999;
  localparam logic [15:0] DEB_12MHZ = 16'd60000;

  function automatic state_t mode_state(input logic [1:0] m);
    return state_t'({1'b0, m});
  endfunction

endpackage

// File: rtl/core_step_ctrl_tick_div.sv
// Programmable free-running divider: period reload+1 cycles, registered 1-cycle tick.
module core_step_ctrl_tick_div #(
  parameter logic [23:0] DEFAULT_DIV = 24'd11999999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_load,
  input  logic [23:0] div_value,
  output logic        tick
);

  logic [23:0] counter;
  logic [23:0] reload;

  always_ff @(posedge clk) begin
    if (rst) begin
      counter <= '0;
      reload  <= DEFAULT_DIV;
      tick    <= 1'b0;
    end else if (div_load) begin
      // restart the period cleanly from the new value
      reload  <= div_value;
      counter <= '0;
      tick    <= 1'b0;
    end else begin
      counter <= (counter >= reload) ? 24'd0 : counter + 24'd1;
      tick    <= (counter == reload);
    end
  end

endmodule

// File: rtl/core_step_ctrl.sv
// Core clock-enable controller: HALT/RUN/SLOW/STEP modes plus a PC breakpoint
// that stops the core before the matched instruction commits.
module core_step_ctrl
  import core_step_ctrl_pkg::*;
#(
  parameter logic [23:0] DEFAULT_DIV = DIV_12MHZ,
  parameter logic [15:0] DEBOUNCE    = DEB_12MHZ,
  parameter int          PC_W        = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      mode_sel,
  input  logic            div_load,
  input  logic [23:0]     div_value,
  input  logic            step_btn,
  input  logic            bp_en,
  input  logic [PC_W-1:0] bp_addr,
  input  logic [PC_W-1:0] pc,
  input  logic            resume,
  output logic            core_en,
  output logic            tick,
  output logic            bp_hit,
  output logic [2:0]      state
);

  state_t      st;
  logic        bp_armed;
  logic        btn_s1, btn_s2, btn_db, step_pulse;
  logic [15:0] db_cnt;
  logic        bp_match, en_raw;

  core_step_ctrl_tick_div #(.DEFAULT_DIV(DEFAULT_DIV)) u_div (
    .clk       (clk),
    .rst       (rst),
    .div_load  (div_load),
    .div_value (div_value),
    .tick      (tick)
  );

  // Button: 2-FF sync, then the level must differ from the debounced value for
  // DEBOUNCE consecutive cycles before it is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1     <= 1'b0;
      btn_s2     <= 1'b0;
      btn_db     <= 1'b0;
      db_cnt     <= '0;
      step_pulse <= 1'b0;
    end else begin
      btn_s1     <= step_btn;
      btn_s2     <= btn_s1;
      step_pulse <= 1'b0;
      if (btn_s2 == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt >= DEBOUNCE - 16'd1) begin
        btn_db     <= btn_s2;
        db_cnt     <= '0;
        step_pulse <= btn_s2;
      end else begin
        db_cnt <= db_cnt + 16'd1;
      end
    end
  end

  assign bp_match = bp_en && (pc == bp_addr);

  always_comb begin
    en_raw = 1'b0;
    unique case (st)
      ST_RUN:  en_raw = 1'b1;
      ST_SLOW: en_raw = tick;
      ST_STEP: en_raw = step_pulse;
      default: en_raw = 1'b0;
    endcase
  end

  assign core_en = en_raw && !(bp_match && bp_armed);
  assign state   = st;

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= ST_HALT;
      bp_armed <= 1'b1;
      bp_hit   <= 1'b0;
    end else if (st == ST_BP_HALT) begin
      if (resume) begin
        st     <= mode_state(mode_sel);
        bp_hit <= 1'b0;
      end
    end else if (bp_match && bp_armed && en_raw) begin
      st       <= ST_BP_HALT;
      bp_armed <= 1'b0;
      bp_hit   <= 1'b1;
    end else begin
      st <= mode_state(mode_sel);
      // re-arm only once the breakpointed instruction has actually committed
      if (core_en && !bp_armed) bp_armed <= 1'b1;
    end
  end

endmodule

// File: tb/tb_core_step_ctrl.sv
// Randomised bench for core_step_ctrl against a cycle-level behavioural model.
module tb_core_step_ctrl;
  localparam int D   = 3;
  localparam int DEF = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, div_load, step_btn, bp_en, resume;
  logic [1:0]  mode_sel;
  logic [23:0] div_value;
  logic [31:0] bp_addr, pc;
  logic        core_en, tick, bp_hit;
  logic [2:0]  state;

  core_step_ctrl #(.DEFAULT_DIV(24'd4), .DEBOUNCE(16'd3), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .mode_sel(mode_sel), .div_load(div_load),
    .div_value(div_value), .step_btn(step_btn), .bp_en(bp_en),
    .bp_addr(bp_addr), .pc(pc), .resume(resume), .core_en(core_en),
    .tick(tick), .bp_hit(bp_hit), .state(state)
  );

  int tests = 0, fails = 0;

  // model: st 0..3 = mode, 4 = breakpoint halt; age = edges since reset/div_load
  int m_st, m_age, m_reload;
  bit m_armed, m_pulse, sh1, sh2, db;
  bit hist[$];

  bit chk_on = 0;
  int n_en, n_tick, m_n_en;
  bit last_cen;
  logic d_en, d_tick, d_hit;
  logic [2:0] d_st;

  function automatic bit m_tick();
    return (m_age > 0) && (m_age % (m_reload + 1) == 0);
  endfunction

  function automatic bit m_enraw();
    case (m_st)
      1: return 1'b1;
      2: return m_tick();
      3: return m_pulse;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_match();
    return bp_en && (pc == bp_addr);
  endfunction

  function automatic bit m_cen();
    return m_enraw() && !(m_match() && m_armed);
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_age = 0; m_reload = DEF; m_armed = 1; m_pulse = 0;
    sh1 = 0; sh2 = 0; db = 0; hist.delete();
  endtask

  task automatic model_update();
    bit cen, er, flip, np;
    cen = m_cen(); er = m_enraw();
    if (rst) begin
      model_reset();
      return;
    end
    if (div_load) begin m_reload = int'(div_value); m_age = 0; end
    else m_age++;
    // debounced level flips once the last D synchronised samples all disagree with it
    hist.push_back(sh2);
    if (hist.size() > D) void'(hist.pop_front());
    flip = (hist.size() == D);
    foreach (hist[i]) if (hist[i] == db) flip = 0;
    np = 0;
    if (flip) begin db = !db; np = db; end
    sh2 = sh1; sh1 = step_btn; m_pulse = np;
    if (m_st == 4) begin
      if (resume) m_st = int'(mode_sel);
    end else if (m_match() && m_armed && er) begin
      m_st = 4; m_armed = 0;
    end else begin
      if (cen) m_armed = 1;
      m_st = int'(mode_sel);
    end
  endtask

  task automatic cycle();
    #1;
    d_en = core_en; d_tick = tick; d_hit = bp_hit; d_st = state;
    if (chk_on) begin
      cmp("core_en", core_en, m_cen());
      cmp("tick", tick, m_tick());
      cmp("bp_hit", bp_hit, m_st == 4);
      cmp("state", state, m_st);
    end
    if (core_en === 1'b1) n_en++;
    if (tick === 1'b1) n_tick++;
    if (m_cen()) m_n_en++;
    last_cen = m_cen();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int guard;
    model_reset();
    rst = 1; mode_sel = 2'b01; div_load = 0; div_value = 0; step_btn = 0;
    bp_en = 0; bp_addr = 32'h10; pc = 0; resume = 0;

    // 1: reset then RUN
    cycle();
    chk_on = 1;
    cycle();
    cmp("rst_core_en", d_en, 0);
    cmp("rst_state", d_st, 0);
    cmp("rst_bp_hit", d_hit, 0);
    rst = 0;
    cycle();
    cmp("run_1st_cycle", d_en, 0);
    cycle();
    cmp("run_2nd_cycle", d_en, 1);

    // 2: SLOW, reload 4 then 1
    mode_sel = 2'b10;
    cycle();
    n_en = 0; n_tick = 0;
    cycles(20);
    cmp("slow_ticks_div4", n_tick, 4);
    cmp("slow_en_div4", n_en, 4);
    div_load = 1; div_value = 24'd1;
    cycle();
    div_load = 0;
    cycle();
    n_en = 0; n_tick = 0;
    cycles(20);
    cmp("slow_ticks_div1", n_tick, 10);
    cmp("slow_en_div1", n_en, 10);

    // 3: STEP with a bounce at the start of the press
    mode_sel = 2'b11;
    cycle();
    n_en = 0;
    step_btn = 1; cycle();
    step_btn = 0; cycle();
    step_btn = 1; cycles(10);
    step_btn = 0; cycles(8);
    cmp("step_one_pulse", n_en, 1);

    // 4: breakpoint at 0x10 in RUN
    bp_en = 1; bp_addr = 32'h10; pc = 0; mode_sel = 2'b01;
    guard = 0;
    while (pc != 32'h10 && guard < 20) begin
      cycle();
      if (last_cen) pc = pc + 4;
      guard++;
    end
    cmp("bp_reach_guard", guard < 20, 1);
    cycle();
    cmp("bp_suppress_en", d_en, 0);
    cycle();
    cmp("bp_state", d_st, 4);
    cmp("bp_hit_high", d_hit, 1);
    cycles(2);
    cmp("bp_hold_en", d_en, 0);
    resume = 1; cycle();
    resume = 0; cycle();
    cmp("resume_exec_en", d_en, 1);
    cmp("resume_state", d_st, 1);
    pc = 32'h14; cycle();
    cmp("after_bp_en", d_en, 1);

    // 5: re-halt, then reset while halted
    pc = 32'h10; cycle();
    cycle();
    cmp("rehalt_state", d_st, 4);
    rst = 1; cycle();
    rst = 0; cycle();
    cmp("rst_bp_state", d_st, 0);
    cmp("rst_bp_hit", d_hit, 0);

    // 6: SLOW -> RUN -> SLOW with div_load on the switch cycle
    bp_en = 0;
    n_en = 0; m_n_en = 0;
    mode_sel = 2'b10; cycles(13);
    mode_sel = 2'b01; cycles(7);
    mode_sel = 2'b10; div_load = 1; div_value = 24'd2; cycle();
    div_load = 0; cycles(15);
    cmp("mode_mix_en_count", n_en, m_n_en);

    // random phase
    pc = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 15) == 0) mode_sel = 2'($urandom);
      div_load = ($urandom_range(0, 39) == 0);
      div_value = 24'($urandom_range(0, 5));
      if ($urandom_range(0, 5) == 0) step_btn = ~step_btn;
      if ($urandom_range(0, 31) == 0) bp_en = ~bp_en;
      if ($urandom_range(0, 63) == 0) bp_addr = $urandom_range(0, 1) ? 32'h10 : 32'h8;
      resume = ($urandom_range(0, 7) == 0);
      cycle();
      if (last_cen) pc = (pc + 4) % 32'h20;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
